// File: rtl/game_pkg.sv
// game_pkg: result codes, scanner state encoding and cell constants
// shared by the grid win scanner and its window checker.
package game_pkg;

    localparam logic [2:0] RES_OK       = 3'b000;
    localparam logic [2:0] RES_WIN      = 3'b001;
    localparam logic [2:0] RES_RANGE    = 3'b010;
    localparam logic [2:0] RES_OCCUPIED = 3'b011;
    localparam logic [2:0] RES_DRAW     = 3'b100;

    localparam int unsigned CELL_EMPTY = 0;

    typedef enum logic [2:0] {
        IDLE,
        VALIDATE,
        WRITE,
        SCAN,
        REPORT
    } state_t;

endpackage

// File: rtl/line_window_check.sv
// line_window_check: tests the WIN_LEN-cell windows starting at one anchor.
// Diagonal windows exist only when DIAGONAL_CHECK_EN is defined.
module line_window_check #(
    parameter int unsigned GRID_W    = 10,
    parameter int unsigned GRID_H    = 10,
    parameter int unsigned WIN_LEN   = 4,
    parameter int unsigned CELL_BITS = 2
)(
    input  logic [GRID_W*GRID_H*CELL_BITS-1:0] i_grid,
    input  logic [3:0]                         i_anchor_x,
    input  logic [3:0]                         i_anchor_y,
    input  logic [CELL_BITS-1:0]               i_player,
    output logic                               o_hit_h,
    output logic                               o_hit_v,
    output logic                               o_hit_dr,
    output logic                               o_hit_dl
);
    localparam int unsigned NCELLS = GRID_W * GRID_H;
    localparam int unsigned BITW   = $clog2(NCELLS * CELL_BITS);

    // Off-grid coordinates (including unsigned wrap below zero) read cell 0;
    // such windows are already disqualified by the edge test.
    function automatic logic [CELL_BITS-1:0] cell_at(input int unsigned x, input int unsigned y);
        int unsigned     idx;
        logic [BITW-1:0] pos;
        idx = y * GRID_W + x;
        if (x >= GRID_W || y >= GRID_H) idx = 0;
        pos = BITW'(idx * CELL_BITS);
        return i_grid[pos +: CELL_BITS];
    endfunction

    always_comb begin
        int unsigned ax;
        int unsigned ay;
        ax = 32'(i_anchor_x);
        ay = 32'(i_anchor_y);

        o_hit_h = (ax + WIN_LEN <= GRID_W) && (ay < GRID_H);
        o_hit_v = (ay + WIN_LEN <= GRID_H) && (ax < GRID_W);
        for (int unsigned k = 0; k < WIN_LEN; k++) begin
            if (cell_at(ax + k, ay) != i_player) o_hit_h = 1'b0;
            if (cell_at(ax, ay + k) != i_player) o_hit_v = 1'b0;
        end

`ifdef DIAGONAL_CHECK_EN
        o_hit_dr = (ax + WIN_LEN <= GRID_W) && (ay + WIN_LEN <= GRID_H);
        o_hit_dl = (ax + 1 >= WIN_LEN) && (ax < GRID_W) && (ay + WIN_LEN <= GRID_H);
        for (int unsigned k = 0; k < WIN_LEN; k++) begin
            if (cell_at(ax + k, ay + k) != i_player) o_hit_dr = 1'b0;
            if (cell_at(ax - k, ay + k) != i_player) o_hit_dl = 1'b0;
        end
`else
        o_hit_dr = 1'b0;
        o_hit_dl = 1'b0;
`endif
    end

endmodule

// File: rtl/grid_win_scanner.sv
// grid_win_scanner: validates moves, stores them in the grid and scans one
// anchor per cycle for a winning run. Define DIAGONAL_CHECK_EN for diagonals.
module grid_win_scanner
    import game_pkg::*;
#(
    parameter int unsigned GRID_W    = 10,
    parameter int unsigned GRID_H    = 10,
    parameter int unsigned WIN_LEN   = 4,
    parameter int unsigned CELL_BITS = 2
)(
    input  logic                 clock_builtin_50MHZ,
    input  logic                 reset,
    input  logic                 clear_grid,
    input  logic                 move_valid,
    output logic                 move_ready,
    input  logic [3:0]           move_x,
    input  logic [3:0]           move_y,
    input  logic [CELL_BITS-1:0] move_player,
    output logic                 result_valid,
    output logic [2:0]           result_code,
    output logic [CELL_BITS-1:0] win_player,
    output logic [7:0]           move_count
);
    localparam int unsigned NCELLS = GRID_W * GRID_H;
    localparam int unsigned IDXW   = $clog2(NCELLS);

    state_t                       r_state;
    state_t                       w_next;
    logic [CELL_BITS-1:0]         r_cells [NCELLS];
    logic [NCELLS*CELL_BITS-1:0]  w_grid;
    logic [3:0]                   r_x;
    logic [3:0]                   r_y;
    logic [CELL_BITS-1:0]         r_player;
    logic [3:0]                   r_ax;
    logic [3:0]                   r_ay;
    logic [2:0]                   r_pend_code;
    logic [CELL_BITS-1:0]         r_pend_win;
    logic                         r_result_valid;
    logic [2:0]                   r_result_code;
    logic [CELL_BITS-1:0]         r_win_player;
    logic [7:0]                   r_move_count;

    logic                         w_xy_ok;
    logic                         w_bad;
    logic [IDXW-1:0]              w_idx;
    logic                         w_occupied;
    logic                         w_accept;
    logic                         w_last_anchor;
    logic                         w_hit_h;
    logic                         w_hit_v;
    logic                         w_hit_dr;
    logic                         w_hit_dl;
    logic                         w_hit;

    always_comb begin
        w_grid = '0;
        for (int unsigned i = 0; i < NCELLS; i++) begin
            w_grid[i*CELL_BITS +: CELL_BITS] = r_cells[i];
        end
    end

    assign w_xy_ok       = (32'(r_x) < GRID_W) && (32'(r_y) < GRID_H);
    assign w_bad         = !w_xy_ok || (r_player == '0);
    assign w_idx         = w_xy_ok ? IDXW'(32'(r_y) * GRID_W + 32'(r_x)) : '0;
    assign w_occupied    = 32'(r_cells[w_idx]) != CELL_EMPTY;
    assign w_accept      = (r_state == IDLE) && move_valid && !clear_grid;
    assign w_last_anchor = (32'(r_ax) == GRID_W - 1) && (32'(r_ay) == GRID_H - 1);
    assign w_hit         = w_hit_h | w_hit_v | w_hit_dr | w_hit_dl;

    line_window_check #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .WIN_LEN  (WIN_LEN),
        .CELL_BITS(CELL_BITS)
    ) u_window (
        .i_grid    (w_grid),
        .i_anchor_x(r_ax),
        .i_anchor_y(r_ay),
        .i_player  (r_player),
        .o_hit_h   (w_hit_h),
        .o_hit_v   (w_hit_v),
        .o_hit_dr  (w_hit_dr),
        .o_hit_dl  (w_hit_dl)
    );

    always_ff @(posedge clock_builtin_50MHZ or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = VALIDATE;
            VALIDATE: w_next = (w_bad || w_occupied) ? REPORT : WRITE;
            WRITE:    w_next = SCAN;
            SCAN:     if (w_hit || w_last_anchor) w_next = REPORT;
            REPORT:   w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // result_valid is registered, so the strobe appears the cycle after REPORT.
    always_ff @(posedge clock_builtin_50MHZ or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCELLS; i++) r_cells[i] <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_player       <= '0;
            r_ax           <= '0;
            r_ay           <= '0;
            r_pend_code    <= RES_OK;
            r_pend_win     <= '0;
            r_result_valid <= 1'b0;
            r_result_code  <= RES_OK;
            r_win_player   <= '0;
            r_move_count   <= '0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear_grid) begin
                        for (int unsigned i = 0; i < NCELLS; i++) r_cells[i] <= '0;
                        r_move_count <= '0;
                    end else if (move_valid) begin
                        r_x      <= move_x;
                        r_y      <= move_y;
                        r_player <= move_player;
                    end
                end
                VALIDATE: begin
                    r_pend_win <= '0;
                    if (w_bad)           r_pend_code <= RES_RANGE;
                    else if (w_occupied) r_pend_code <= RES_OCCUPIED;
                end
                WRITE: begin
                    r_cells[w_idx] <= r_player;
                    if (r_move_count != 8'hFF) r_move_count <= r_move_count + 8'd1;
                    r_ax <= '0;
                    r_ay <= '0;
                end
                SCAN: begin
                    if (w_hit) begin
                        r_pend_code <= RES_WIN;
                        r_pend_win  <= r_player;
                    end else if (w_last_anchor) begin
                        r_pend_code <= (32'(r_move_count) == NCELLS) ? RES_DRAW : RES_OK;
                        r_pend_win  <= '0;
                    end else if (32'(r_ax) == GRID_W - 1) begin
                        r_ax <= '0;
                        r_ay <= r_ay + 4'd1;
                    end else begin
                        r_ax <= r_ax + 4'd1;
                    end
                end
                REPORT: begin
                    r_result_valid <= 1'b1;
                    r_result_code  <= r_pend_code;
                    r_win_player   <= r_pend_win;
                end
                default: ;
            endcase
        end
    end

    assign move_ready   = (r_state == IDLE) && !clear_grid;
    assign result_valid = r_result_valid;
    assign result_code  = r_result_code;
    assign win_player   = r_win_player;
    assign move_count   = r_move_count;

endmodule

// File: tb/tb_grid_win_scanner.sv
// Directed bench for grid_win_scanner: a 10x10 instance and a 3x3 instance,
// table-driven moves plus clear and mid-scan reset sequences.
module tb_grid_win_scanner;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_a, clr_a, mv_a;
    logic [3:0] mx_a, my_a;
    logic [1:0] mp_a;
    logic       rdy_a, rv_a;
    logic [2:0] rc_a;
    logic [1:0] wp_a;
    logic [7:0] cnt_a;

    logic       rst_b, clr_b, mv_b;
    logic [3:0] mx_b, my_b;
    logic [1:0] mp_b;
    logic       rdy_b, rv_b;
    logic [2:0] rc_b;
    logic [1:0] wp_b;
    logic [7:0] cnt_b;

    grid_win_scanner #(.GRID_W(10), .GRID_H(10), .WIN_LEN(4), .CELL_BITS(2)) dut_a (
        .clock_builtin_50MHZ(clk), .reset(rst_a), .clear_grid(clr_a),
        .move_valid(mv_a), .move_ready(rdy_a), .move_x(mx_a), .move_y(my_a),
        .move_player(mp_a), .result_valid(rv_a), .result_code(rc_a),
        .win_player(wp_a), .move_count(cnt_a)
    );

    grid_win_scanner #(.GRID_W(3), .GRID_H(3), .WIN_LEN(3), .CELL_BITS(2)) dut_b (
        .clock_builtin_50MHZ(clk), .reset(rst_b), .clear_grid(clr_b),
        .move_valid(mv_b), .move_ready(rdy_b), .move_x(mx_b), .move_y(my_b),
        .move_player(mp_b), .result_valid(rv_b), .result_code(rc_b),
        .win_player(wp_b), .move_count(cnt_b)
    );

    logic       cur;
    logic       o_rdy, o_rv;
    logic [2:0] o_rc;
    logic [1:0] o_wp;
    logic [7:0] o_cnt;
    assign o_rdy = cur ? rdy_b : rdy_a;
    assign o_rv  = cur ? rv_b  : rv_a;
    assign o_rc  = cur ? rc_b  : rc_a;
    assign o_wp  = cur ? wp_b  : wp_a;
    assign o_cnt = cur ? cnt_b : cnt_a;

    typedef struct {
        int sel;
        int x;
        int y;
        int p;
        int code;
        int win;
        int cnt;
        int lat;
    } vec_t;

    vec_t vecs[40];
    int   nvec = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   cur_vec = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (vector %0d): got %0d, expected %0d", name, cur_vec, act, exp);
    endtask

    task automatic add(input int sel, input int x, input int y, input int p,
                       input int code, input int win, input int cnt, input int lat);
        vecs[nvec] = '{sel, x, y, p, code, win, cnt, lat};
        nvec++;
    endtask

    task automatic drive(input int sel, input logic v, input int x, input int y,
                         input int p, input logic c);
        if (sel == 0) begin
            mv_a = v; mx_a = 4'(x); my_a = 4'(y); mp_a = 2'(p); clr_a = c;
        end else begin
            mv_b = v; mx_b = 4'(x); my_b = 4'(y); mp_b = 2'(p); clr_b = c;
        end
    endtask

    // Called at 1 time unit after a rising edge with the selected DUT idle.
    task automatic apply(input vec_t v);
        int cyc;
        bit seen;
        cur = (v.sel != 0);
        drive(v.sel, 1'b1, v.x, v.y, v.p, 1'b0);
        #0;
        chk("move_ready", int'(o_rdy), 1);
        @(posedge clk); #1;
        drive(v.sel, 1'b0, 0, 0, 0, 1'b0);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (o_rv) seen = 1'b1;
        end
        chk("result_valid_seen", int'(seen), 1);
        chk("result_code", int'(o_rc), v.code);
        chk("win_player", int'(o_wp), v.win);
        chk("move_count", int'(o_cnt), v.cnt);
        chk("latency", cyc, v.lat);
        @(posedge clk); #1;
        chk("pulse_width", int'(o_rv), 0);
        chk("code_hold", int'(o_rc), v.code);
    endtask

    initial begin
        int  seen_rv;
        vec_t v;

        // 10x10 board
        add(0, 3, 2, 1, 0, 0, 1, 103);
        add(0, 3, 2, 2, 3, 0, 1, 2);
        add(0, 0, 2, 2, 0, 0, 2, 103);
        add(0, 1, 2, 2, 0, 0, 3, 103);
        add(0, 2, 2, 2, 0, 0, 4, 103);   // (3,2) must still be player 1
        add(0, 0, 5, 1, 0, 0, 5, 103);
        add(0, 1, 5, 1, 0, 0, 6, 103);
        add(0, 2, 5, 1, 0, 0, 7, 103);
        add(0, 3, 5, 1, 1, 1, 8, 54);
        add(0, 10, 0, 1, 2, 0, 8, 2);
        add(0, 0, 10, 1, 2, 0, 8, 2);
        add(0, 9, 9, 0, 2, 0, 8, 2);
        add(0, 6, 0, 2, 0, 0, 9, 103);
        add(0, 5, 1, 2, 0, 0, 10, 103);
        add(0, 4, 2, 2, 0, 0, 11, 103);
`ifdef DIAGONAL_CHECK_EN
        add(0, 3, 3, 2, 1, 2, 12, 10);
`else
        add(0, 3, 3, 2, 0, 0, 12, 103);
`endif
        add(0, 8, 0, 3, 0, 0, 13, 103);
        add(0, 9, 0, 3, 0, 0, 14, 103);
        add(0, 0, 1, 3, 0, 0, 15, 103);
        add(0, 1, 1, 3, 0, 0, 16, 103);
        add(0, 9, 6, 3, 0, 0, 17, 103);
        add(0, 9, 7, 3, 0, 0, 18, 103);
        add(0, 9, 8, 3, 0, 0, 19, 103);
        add(0, 9, 9, 3, 1, 3, 20, 73);
        add(0, 9, 6, 1, 3, 0, 20, 2);
`ifdef DIAGONAL_CHECK_EN
        add(0, 5, 5, 2, 1, 2, 21, 10);
`else
        add(0, 5, 5, 2, 0, 0, 21, 103);
`endif
        // 3x3 board, no line anywhere, including diagonals
        add(1, 0, 0, 1, 0, 0, 1, 12);
        add(1, 1, 0, 2, 0, 0, 2, 12);
        add(1, 2, 0, 1, 0, 0, 3, 12);
        add(1, 0, 1, 1, 0, 0, 4, 12);
        add(1, 1, 1, 2, 0, 0, 5, 12);
        add(1, 2, 1, 2, 0, 0, 6, 12);
        add(1, 0, 2, 2, 0, 0, 7, 12);
        add(1, 1, 2, 1, 0, 0, 8, 12);
        add(1, 2, 2, 1, 4, 0, 9, 12);

        cur = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        chk("reset_move_ready", int'(rdy_a), 1);
        chk("reset_result_valid", int'(rv_a), 0);
        chk("reset_result_code", int'(rc_a), 0);
        chk("reset_win_player", int'(wp_a), 0);
        chk("reset_move_count", int'(cnt_a), 0);
        chk("reset_move_ready_b", int'(rdy_b), 1);

        for (int i = 0; i < nvec; i++) begin
            cur_vec = i;
            apply(vecs[i]);
        end

        // Clear and move together: clear wins, move is dropped.
        cur_vec = 100;
        cur = 1'b0;
        drive(0, 1'b1, 4, 4, 1, 1'b1);
        #0;
        chk("clear_move_ready", int'(rdy_a), 0);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0, 0, 1'b0);
        chk("clear_move_count", int'(cnt_a), 0);
        seen_rv = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rv_a) seen_rv++;
        end
        chk("clear_no_result", seen_rv, 0);
        v = '{0, 3, 2, 1, 0, 0, 1, 103};
        apply(v);

        // Mid-scan reset on the 3x3 board.
        cur_vec = 101;
        cur = 1'b1;
        drive(1, 1'b0, 0, 0, 0, 1'b1);
        @(posedge clk); #1;
        drive(1, 1'b0, 0, 0, 0, 1'b0);
        chk("clear_b_count", int'(cnt_b), 0);
        drive(1, 1'b1, 0, 0, 1, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #4;
        chk("pre_reset_count", int'(cnt_b), 1);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("midscan_move_ready", int'(rdy_b), 1);
        chk("midscan_result_valid", int'(rv_b), 0);
        chk("midscan_result_code", int'(rc_b), 0);
        chk("midscan_win_player", int'(wp_b), 0);
        chk("midscan_move_count", int'(cnt_b), 0);
        rst_b = 1'b0;
        seen_rv = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (rv_b) seen_rv++;
        end
        chk("midscan_no_result", seen_rv, 0);
        v = '{1, 0, 0, 2, 0, 0, 1, 12};
        apply(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
